instr_encoder_loader: RTL and testbench

//  Streams field-level instruction requests, encodes each into a 32-bit RV32I word
//  (R, I, B, lw, sw, jal: the opcode set consumed by the control decoder), and writes
//  the words sequentially into instruction memory. Serves as the test/boot program

---
 rtl/instr_encoder_loader.sv | 208 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//   Boot/test program loader for the single-cycle core's instruction memory.
//   Accepts field-level instruction requests over a valid/ready handshake,
//   encodes each into a 32-bit RV32I word (R, I-ALU, B, lw, sw, jal) and
//   writes the words to consecutive word addresses starting at BASE_ADDR.
//   Each accepted request appears on the write port one cycle later.
//
//   Optional feature macro: ENC_RANGE_CHECK_EN
//     defined     : out-of-range or misaligned immediates are replaced by a
//                   nop and flag err.
//     not defined : immediates are truncated to the field width and bit 0 is
//                   dropped for B/jal offsets. Only illegal kinds flag err.
//
// Parameters
//   ADDR_W     word-address width, capacity = 2**ADDR_W words
//   BASE_ADDR  byte address of the first word written (word aligned)
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             arms a load (sampled in IDLE and DONE only)
//   req_valid/ready   request handshake, ready only while loading
//   req_last          marks the final request of the program
//   req_kind          0 R, 1 I-ALU, 2 B, 3 lw, 4 sw, 5 jal, 6-7 illegal
//   req_rd/rs1/rs2    register fields
//   req_funct3        funct3 for R/I/B (lw/sw always use 3'b010)
//   req_funct7b5      funct7[5] for R, and for I shifts with funct3=101
//   req_imm           signed immediate (byte offset for B/jal)
//   imem_we/addr/wd   instruction memory write port
//   busy              loading or a write still pending
//   done              load finished
//   overflow          capacity reached without req_last (sticky until start)
//   err               illegal request seen this load (sticky until start)
//   instr_count       words written this load
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic              req_funct7b5,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err,
    output logic [ADDR_W:0]   instr_count
);

    localparam logic [31:0]     NOP = 32'h0000_0013;
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_acc;
    logic            w_clear;
    logic [ADDR_W:0] r_count;
    logic [ADDR_W:0] w_count_inc;
    logic            r_err;
    logic            r_ovf;
    logic            r_vld_p1;
    logic [31:0]     r_wd_p1;
    logic [31:0]     r_addr_p1;
    logic [31:0]     w_word;
    logic            w_bad;
    logic [11:0]     w_imm_i;
    logic            w_range_bad;

    assign w_count_inc = r_count + {{ADDR_W{1'b0}}, 1'b1};

`ifdef ENC_RANGE_CHECK_EN
    // True when v sign-extends from its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] sv;
        sv = $signed(v) >>> (bits - 1);
        return (sv == '0) || (sv == '1);
    endfunction

    always_comb begin
        w_range_bad = 1'b0;
        case (req_kind)
            3'd1, 3'd3, 3'd4: w_range_bad = !fits_signed(req_imm, 12);
            3'd2:             w_range_bad = !fits_signed(req_imm, 13) || req_imm[0];
            3'd5:             w_range_bad = !fits_signed(req_imm, 21) || req_imm[0];
            default:          w_range_bad = 1'b0;
        endcase
    end
`else
    // High immediate bits are deliberately ignored when truncating.
    logic w_unused_imm;
    assign w_unused_imm = ^req_imm[31:21];
    assign w_range_bad  = 1'b0;
`endif

    // Encoder: combinational in front of the accept edge.
    always_comb begin
        w_word  = NOP;
        w_bad   = 1'b0;
        // Immediate shifts (funct3=101) carry funct7 in imm[11:5].
        w_imm_i = req_imm[11:0];
        if (req_funct3 == 3'b101) begin
            w_imm_i = {1'b0, req_funct7b5, 5'b0, req_imm[4:0]};
        end
        case (req_kind)
            3'd0: w_word = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
            3'd1: w_word = {w_imm_i, req_rs1, req_funct3, req_rd, 7'b0010011};
            3'd2: w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], 7'b1100011};
            3'd3: w_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
            3'd4: w_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
            3'd5: w_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
            default: begin
                w_word = NOP;
                w_bad  = 1'b1;
            end
        endcase
        if (w_range_bad) begin
            w_word = NOP;
            w_bad  = 1'b1;
        end
    end

    // Control FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (req_valid) begin
                    w_acc = 1'b1;
                    if (req_last || (w_count_inc == CAP)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: control state, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vld_p1 <= w_acc;
            if (w_clear) begin
                r_count <= '0;
                r_err   <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_acc) begin
                // Count moves with the accept so it already reads N during the Nth write.
                r_count <= w_count_inc;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
                if (!req_last && (w_count_inc == CAP)) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Stage p0 -> p1: write data, qualified by r_vld_p1 so no reset needed.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_wd_p1   <= w_word;
            r_addr_p1 <= BASE_ADDR + (32'(r_count) << 2);
        end
    end

    assign req_ready   = (r_state == S_LOAD);
    assign imem_we     = r_vld_p1;
    assign imem_addr   = r_vld_p1 ? r_addr_p1 : 32'h0;
    assign imem_wd     = r_vld_p1 ? r_wd_p1 : 32'h0;
    assign busy        = (r_state == S_LOAD) || r_vld_p1;
    assign done        = (r_state == S_DONE);
    assign overflow    = r_ovf;
    assign err         = r_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        req_valid, req_last, req_f7;
    logic [2:0]  req_kind, req_f3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;

    logic        rdy_a, we_a, busy_a, done_a, ovf_a, err_a;
    logic [31:0] addr_a, wd_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, we_b, busy_b, done_b, ovf_b, err_b;
    logic [31:0] addr_b, wd_b;
    logic [2:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    int ma_cnt, mb_cnt;
    logic ma_err, mb_err;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] ea, eb;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(BASE_A)) u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .req_valid(req_valid), .req_ready(rdy_a), .req_last(req_last),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_f3), .req_funct7b5(req_f7), .req_imm(req_imm),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wd(wd_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .err(err_a), .instr_count(cnt_a)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(BASE_B)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .req_valid(req_valid), .req_ready(rdy_b), .req_last(req_last),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_f3), .req_funct7b5(req_f7), .req_imm(req_imm),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wd(wd_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .err(err_b), .instr_count(cnt_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference encoder built from the RV32I field positions with shifts and masks.
    function automatic logic [31:0] ref_word(input logic [2:0] k, input logic [4:0] d, s1, s2,
                                             input logic [2:0] f3, input logic f7,
                                             input logic [31:0] imm);
        logic [31:0] rd, r1, r2, ff, w;
        rd = 32'(d) << 7; r1 = 32'(s1) << 15; r2 = 32'(s2) << 20; ff = 32'(f3) << 12;
        case (k)
            3'd0: w = (32'(f7) << 30) | r2 | r1 | ff | rd | 32'h33;
            3'd1: begin
                if (f3 == 3'd5) w = (((32'(f7) << 10) | (imm & 32'h1F)) << 20) | r1 | ff | rd | 32'h13;
                else            w = ((imm & 32'hFFF) << 20) | r1 | ff | rd | 32'h13;
            end
            3'd2: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | ff
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            3'd3: w = ((imm & 32'hFFF) << 20) | r1 | (32'd2 << 12) | rd | 32'h03;
            3'd4: w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | (32'd2 << 12)
                      | ((imm & 32'h1F) << 7) | 32'h23;
            3'd5: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rd | 32'h6F;
            default: w = 32'h13;
        endcase
        return w;
    endfunction

    function automatic logic ref_bad(input logic [2:0] k, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (k >= 3'd6) return 1'b1;
`ifdef ENC_RANGE_CHECK_EN
        case (k)
            3'd1, 3'd3, 3'd4: return (s < -2048) || (s > 2047);
            3'd2:             return (s < -4096) || (s > 4095) || imm[0];
            3'd5:             return (s < -1048576) || (s > 1048575) || imm[0];
            default:          return 1'b0;
        endcase
`else
        return (s != s);
`endif
    endfunction

    function automatic logic [31:0] rnd_imm();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: v = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
            2: begin
                case ($urandom_range(0, 7))
                    0: v = 32'd2047;
                    1: v = 32'd2048;
                    2: v = -32'd2048;
                    3: v = -32'd2049;
                    4: v = 32'd4094;
                    5: v = -32'd4096;
                    6: v = 32'd1048574;
                    default: v = 32'd1048576;
                endcase
            end
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Monitors: every write must match the next expected {addr, word}.
    always @(negedge clk) begin
        if (we_a) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write_a: got addr %h word %h want no write", addr_a, wd_a);
            end else begin
                ea = qa.pop_front();
                chk("addr_a", addr_a, ea[63:32]);
                chk("word_a", wd_a, ea[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (we_b) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write_b: got addr %h word %h want no write", addr_b, wd_b);
            end else begin
                eb = qb.pop_front();
                chk("addr_b", addr_b, eb[63:32]);
                chk("word_b", wd_b, eb[31:0]);
            end
        end
    end

    // Called just after a negedge; returns at the negedge where the word is written.
    task automatic send(input bit b, input logic [2:0] k, input logic [4:0] d, s1, s2,
                        input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                        input logic last, input logic [31:0] exp_w, input logic exp_bad);
        int n;
        req_valid = 1'b1; req_kind = k; req_rd = d; req_rs1 = s1; req_rs2 = s2;
        req_f3 = f3; req_f7 = f7; req_imm = imm; req_last = last;
        n = 0;
        while (((b ? rdy_b : rdy_a) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL ready_timeout: got ready=0 for %0d cycles want ready=1", n);
            req_valid = 1'b0;
            return;
        end
        if (b) begin
            qb.push_back({BASE_B + 32'(4 * mb_cnt), exp_w});
            mb_cnt++;
            mb_err = mb_err | exp_bad;
        end else begin
            qa.push_back({BASE_A + 32'(4 * ma_cnt), exp_w});
            ma_cnt++;
            ma_err = ma_err | exp_bad;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (b) chk("count_b", 32'(cnt_b), 32'(mb_cnt));
        else   chk("count_a", 32'(cnt_a), 32'(ma_cnt));
    endtask

    task automatic arm(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        if (b) begin
            mb_cnt = 0; mb_err = 1'b0;
            chk("arm_ready_b", 32'(rdy_b), 32'd1);
            chk("arm_count_b", 32'(cnt_b), 32'd0);
            chk("arm_ovf_b", 32'(ovf_b), 32'd0);
        end else begin
            ma_cnt = 0; ma_err = 1'b0;
            chk("arm_ready_a", 32'(rdy_a), 32'd1);
            chk("arm_count_a", 32'(cnt_a), 32'd0);
            chk("arm_err_a", 32'(err_a), 32'd0);
            chk("arm_ovf_a", 32'(ovf_a), 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] w;
        logic        bad;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  k, f3;
        logic [4:0]  d, s1, s2;
        logic        f7;
        logic [31:0] imm;

        tbl[0]  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,         32'h002081B3, 1'b0};
        tbl[1]  = '{3'd3, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8,         32'h00812283, 1'b0};
        tbl[2]  = '{3'd4, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 32'd4,         32'h00512223, 1'b0};
        tbl[3]  = '{3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0};
        tbl[4]  = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,         32'h00500093, 1'b0};
        tbl[5]  = '{3'd1, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1, 32'd4,         32'h4041D113, 1'b0};
        tbl[6]  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,         32'h402081B3, 1'b0};
        tbl[7]  = '{3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF,  32'hFFF08093, 1'b0};
        tbl[8]  = '{3'd7, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,         32'h00000013, 1'b1};
        tbl[9]  = '{3'd6, 5'd9, 5'd4, 5'd7, 3'd1, 1'b1, 32'd12,        32'h00000013, 1'b1};
`ifdef ENC_RANGE_CHECK_EN
        tbl[10] = '{3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd4096,      32'h00000013, 1'b1};
`else
        tbl[10] = '{3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd4096,      32'h00008093, 1'b0};
`endif
        tbl[11] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,         32'h008000EF, 1'b0};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        req_valid = 1'b0; req_last = 1'b0; req_kind = '0; req_rd = '0; req_rs1 = '0;
        req_rs2 = '0; req_f3 = '0; req_f7 = 1'b0; req_imm = '0;
        ma_cnt = 0; mb_cnt = 0; ma_err = 1'b0; mb_err = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", addr_a, 32'd0);
        chk("rst_wd", wd_a, 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_flags", {30'd0, ovf_a, err_a}, 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        reset = 1'b0;

        // Requests offered in IDLE are not taken.
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        chk("idle_ready", 32'(rdy_a), 32'd0);
        chk("idle_count", 32'(cnt_a), 32'd0);

        // Directed table, back to back, last on final entry.
        arm(1'b0);
        for (int i = 0; i < 12; i++) begin
            send(1'b0, tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7,
                 tbl[i].imm, (i == 11), tbl[i].w, tbl[i].bad);
        end
        chk("tbl_done", 32'(done_a), 32'd1);
        chk("tbl_ready", 32'(rdy_a), 32'd0);
        chk("tbl_err", 32'(err_a), 32'(ma_err));
        chk("tbl_ovf", 32'(ovf_a), 32'd0);
        chk("tbl_count", 32'(cnt_a), 32'd12);
        @(negedge clk);
        chk("tbl_busy", 32'(busy_a), 32'd0);
        chk("tbl_drained", 32'(qa.size()), 32'd0);

        // Randomized load; start toggled while loading must be ignored.
        arm(1'b0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            k = 3'($urandom_range(0, 7)); d = 5'($urandom()); s1 = 5'($urandom());
            s2 = 5'($urandom()); f3 = 3'($urandom()); f7 = 1'($urandom()); imm = rnd_imm();
            start_a = ($urandom_range(0, 3) == 0);
            send(1'b0, k, d, s1, s2, f3, f7, imm, (i == 39),
                 ref_bad(k, imm) ? 32'h13 : ref_word(k, d, s1, s2, f3, f7, imm), ref_bad(k, imm));
        end
        start_a = 1'b0;
        chk("rnd_done", 32'(done_a), 32'd1);
        chk("rnd_err", 32'(err_a), 32'(ma_err));
        chk("rnd_count", 32'(cnt_a), 32'd40);
        chk("rnd_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        chk("rnd_drained", 32'(qa.size()), 32'd0);

        // Capacity reached without last on the 4-word instance.
        arm(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 3'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i),
                 1'b0, ref_word(3'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i)), 1'b0);
        end
        chk("ovf_flag", 32'(ovf_b), 32'd1);
        chk("ovf_done", 32'(done_b), 32'd1);
        chk("ovf_ready", 32'(rdy_b), 32'd0);
        chk("ovf_count", 32'(cnt_b), 32'd4);
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        chk("ovf_drained", 32'(qb.size()), 32'd0);
        chk("ovf_count_hold", 32'(cnt_b), 32'd4);
        chk("a_untouched", 32'(cnt_a), 32'd40);

        // Reset mid-load: two accepts, then reset while a third is offered.
        arm(1'b0);
        send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'h002081B3, 1'b0);
        send(1'b0, 3'd7, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'h00000013, 1'b1);
        req_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("mid_we", 32'(we_a), 32'd0);
        chk("mid_count", 32'(cnt_a), 32'd0);
        chk("mid_ready", 32'(rdy_a), 32'd0);
        chk("mid_busy", 32'(busy_a), 32'd0);
        chk("mid_done", 32'(done_a), 32'd0);
        chk("mid_err", 32'(err_a), 32'd0);
        chk("mid_ovf_b", 32'(ovf_b), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        chk("post_count", 32'(cnt_a), 32'd0);
        chk("post_drained", 32'(qa.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
